// File: rtl/register_seq_if.sv
// Command handshake bundle between a command source and the register sequencer.
interface register_seq_if #(
  parameter int unsigned SW = 3,
  parameter int unsigned MW = 4,
  parameter int unsigned DW = 16
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [SW-1:0] cmd_op;
  logic [MW-1:0] cmd_m;
  logic [DW-1:0] cmd_d;

  modport master (output cmd_valid, cmd_op, cmd_m, cmd_d, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_m, cmd_d, output cmd_ready);
endinterface

// File: rtl/register_seq.sv
// Command sequencer feeding the 16-bit shift register: queues {op, M, D}
// commands and plays each one out as HOLD_CYC clocks of set=op, then a gap clock.
module register_seq #(
  parameter int unsigned DW         = 16,
  parameter int unsigned MW         = 4,
  parameter int unsigned SW         = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned HOLD_CYC   = 3
) (
  input  logic                                 clk,
  input  logic                                 res,
  register_seq_if.slave                        cmd,
  input  logic                                 abort,
  output logic [SW-1:0]                        set,
  output logic [MW-1:0]                        M,
  output logic [DW-1:0]                        D,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      level
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_t;

  logic [SW-1:0] op_mem [FIFO_DEPTH];
  logic [MW-1:0] m_mem  [FIFO_DEPTH];
  logic [DW-1:0] d_mem  [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count, count_next_c;
  logic          ready_q;
  logic          push_c, pop_c;

  state_t        state, state_n;
  logic [SW-1:0] set_n;
  logic [MW-1:0] m_n;
  logic [DW-1:0] d_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          busy_n, done_n, err_n;

  assign cmd.cmd_ready = ready_q;
  assign level         = count;
  assign push_c        = cmd.cmd_valid & ready_q & ~abort;
  assign count_next_c  = count + LW'(push_c) - LW'(pop_c);

  // Command storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_c) begin
      op_mem[wr_ptr] <= cmd.cmd_op;
      m_mem[wr_ptr]  <= cmd.cmd_m;
      d_mem[wr_ptr]  <= cmd.cmd_d;
    end
  end

  // FIFO pointers, occupancy and registered ready (abort flushes everything).
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else if (abort) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b1;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
      count   <= count_next_c;
      ready_q <= (count_next_c != LW'(FIFO_DEPTH));
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= S_IDLE;
      set   <= '0;
      M     <= '0;
      D     <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      set   <= set_n;
      M     <= m_n;
      D     <= d_n;
      cnt   <= cnt_n;
      busy  <= busy_n;
      done  <= done_n;
      err   <= err_n;
    end
  end

  // Next-state and next-output decode; pops the head command only from IDLE.
  always_comb begin
    state_n = state;
    set_n   = set;
    m_n     = M;
    d_n     = D;
    cnt_n   = cnt;
    busy_n  = busy;
    done_n  = 1'b0;
    err_n   = 1'b0;
    pop_c   = 1'b0;
    if (abort) begin
      state_n = S_IDLE;
      set_n   = '0;
      busy_n  = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          set_n  = '0;
          busy_n = 1'b0;
          if (count != '0) begin
            pop_c = 1'b1;
            if (op_mem[rd_ptr] == '0) begin
              state_n = S_GAP;
              busy_n  = 1'b1;
              done_n  = 1'b1;
            end else if (op_mem[rd_ptr] <= SW'(4)) begin
              state_n = S_ACTIVE;
              set_n   = op_mem[rd_ptr];
              m_n     = m_mem[rd_ptr];
              d_n     = d_mem[rd_ptr];
              cnt_n   = CW'(HOLD_CYC - 1);
              busy_n  = 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end
        end
        S_ACTIVE: begin
          if (cnt == '0) begin
            state_n = S_GAP;
            set_n   = '0;
            done_n  = 1'b1;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
        S_GAP: begin
          state_n = S_IDLE;
          set_n   = '0;
          busy_n  = 1'b0;
        end
        default: begin
          state_n = S_IDLE;
          set_n   = '0;
          busy_n  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_seq.sv
// Scoreboard bench for register_seq: accepted commands are queued and
// retired against done/err pulses, plus directed timing checks.
module tb_register_seq;

  localparam int unsigned DW = 16, MW = 4, SW = 3, DEPTH = 4, HOLD = 3;

  logic          clk = 1'b0;
  logic          res = 1'b0;
  logic          abort = 1'b0;
  logic [SW-1:0] set;
  logic [MW-1:0] M;
  logic [DW-1:0] D;
  logic          busy, done, err;
  logic [2:0]    level;

  register_seq_if #(.SW(SW), .MW(MW), .DW(DW)) cmd_bus ();

  register_seq #(.DW(DW), .MW(MW), .SW(SW), .FIFO_DEPTH(DEPTH), .HOLD_CYC(HOLD)) dut (
    .clk(clk), .res(res), .cmd(cmd_bus), .abort(abort), .set(set), .M(M), .D(D),
    .busy(busy), .done(done), .err(err), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] op;
    logic [MW-1:0] m;
    logic [DW-1:0] d;
  } cmd_t;

  cmd_t sb[$];
  cmd_t mon_e;
  int   n_checks = 0, n_fail = 0;
  int   done_cnt = 0, err_cnt = 0;
  int   len = 0, zero_run = 0;
  bit   tight = 0, tight_seen = 0, saw_full = 0;
  logic [SW-1:0] last_set = '0, prev_set = '0;
  logic [MW-1:0] last_m = '0;
  logic [DW-1:0] last_d = '0;
  logic [SW-1:0] burst_ops [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Retire commands against the DUT's done/err pulses and watch timing invariants.
  always @(negedge clk) begin
    if (!res) begin
      len = 0; last_set = '0; prev_set = '0; zero_run = 0; tight_seen = 0;
    end else begin
      check("level_le_depth", 32'(32'(level) <= DEPTH), 1);
      if (32'(level) == DEPTH) begin
        saw_full = 1;
        check("ready_at_full", 32'(cmd_bus.cmd_ready), 0);
      end
      if (!busy) begin len = 0; last_set = '0; end
      if (set != '0) begin
        if (prev_set == '0) begin
          if (tight && tight_seen) check("gap_len", 32'(zero_run), 2);
          if (tight) tight_seen = 1;
          zero_run = 0;
        end
        len++; last_set = set; last_m = M; last_d = D;
      end else begin
        zero_run++;
      end
      if (!tight) tight_seen = 0;
      if (err) begin
        err_cnt++;
        check("err_set_zero", 32'(set), 0);
        if (sb.size() == 0) check("err_unexpected", 0, 1);
        else begin
          mon_e = sb.pop_front();
          check("err_op_illegal", 32'(mon_e.op), 32'(mon_e.op >= 3'd5 ? mon_e.op : 3'd5));
        end
      end
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) check("done_unexpected", 0, 1);
        else begin
          mon_e = sb.pop_front();
          check("done_op", 32'(last_set), 32'(mon_e.op));
          if (mon_e.op != '0) begin
            check("hold_len", 32'(len), HOLD);
            check("done_m", 32'(last_m), 32'(mon_e.m));
            check("done_d", 32'(last_d), 32'(mon_e.d));
          end else begin
            check("nop_len", 32'(len), 0);
          end
        end
      end
      prev_set = set;
    end
  end

  // Present one command (valid left high) and wait, bounded, until it is accepted.
  task automatic send(input logic [SW-1:0] op, input logic [MW-1:0] m, input logic [DW-1:0] d);
    int t = 0;
    cmd_t c;
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = op;
    cmd_bus.cmd_m     = m;
    cmd_bus.cmd_d     = d;
    while (!cmd_bus.cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("send_timeout", 0, 1);
    else begin
      c.op = op; c.m = m; c.d = d;
      sb.push_back(c);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb.size() != 0 || busy || level != '0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 32'(t < 300), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0;
    logic [SW-1:0] rop;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op    = '0;
    cmd_bus.cmd_m     = '0;
    cmd_bus.cmd_d     = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_set", 32'(set), 0);
    check("rst_m", 32'(M), 0);
    check("rst_d", 32'(D), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_level", 32'(level), 0);
    check("rst_ready", 32'(cmd_bus.cmd_ready), 0);
    res = 1'b1;
    #1 check("ready_before_edge", 32'(cmd_bus.cmd_ready), 0);
    @(negedge clk);
    check("ready_after_release", 32'(cmd_bus.cmd_ready), 1);

    // Single command: exact cycle timing
    send(3'd1, 4'd3, 16'h0269);
    cmd_bus.cmd_valid = 1'b0;
    check("single_level", 32'(level), 1);
    check("single_pre_set", 32'(set), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("single_set", 32'(set), 1);
      check("single_m", 32'(M), 3);
      check("single_d", 32'(D), 32'h0269);
      check("single_busy", 32'(busy), 1);
    end
    @(negedge clk);
    check("single_gap_set", 32'(set), 0);
    check("single_done", 32'(done), 1);
    @(negedge clk);
    check("single_done_low", 32'(done), 0);
    check("single_idle_busy", 32'(busy), 0);

    // Burst of 6 with valid held high
    d0 = done_cnt;
    saw_full = 0;
    tight = 1;
    for (int i = 0; i < 6; i++)
      send(burst_ops[i], MW'(i + 2), DW'(32'h1000 * (i + 1) + i));
    cmd_bus.cmd_valid = 1'b0;
    wait_idle();
    tight = 0;
    check("burst_done_count", 32'(done_cnt - d0), 6);
    check("burst_saw_full", 32'(saw_full), 1);

    // Illegal op followed by a legal one
    d0 = done_cnt;
    e0 = err_cnt;
    send(3'd6, 4'd1, 16'h1111);
    send(3'd2, 4'd7, 16'hBEEF);
    cmd_bus.cmd_valid = 1'b0;
    wait_idle();
    check("illegal_err_count", 32'(err_cnt - e0), 1);
    check("illegal_done_count", 32'(done_cnt - d0), 1);

    // Abort in the second ACTIVE clock with two queued
    d0 = done_cnt;
    send(3'd3, 4'd2, 16'h0A0A);
    send(3'd4, 4'd1, 16'h0B0B);
    send(3'd1, 4'd9, 16'h0C0C);
    check("abort_pre_set", 32'(set), 3);
    check("abort_pre_level", 32'(level), 2);
    abort = 1'b1;
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op = 3'd4;
    @(negedge clk);
    abort = 1'b0;
    cmd_bus.cmd_valid = 1'b0;
    sb.delete();
    check("abort_set", 32'(set), 0);
    check("abort_level", 32'(level), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_ready", 32'(cmd_bus.cmd_ready), 1);
    repeat (8) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 0);
    check("abort_stays_idle", 32'(busy), 0);
    check("abort_level_hold", 32'(level), 0);

    // NOP: GAP only
    d0 = done_cnt;
    send(3'd0, 4'd5, 16'hAAAA);
    cmd_bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("nop_busy", 32'(busy), 1);
    check("nop_done", 32'(done), 1);
    check("nop_set", 32'(set), 0);
    @(negedge clk);
    check("nop_busy_low", 32'(busy), 0);
    check("nop_done_low", 32'(done), 0);
    check("nop_done_count", 32'(done_cnt - d0), 1);

    // Reset during ACTIVE
    send(3'd2, 4'd4, 16'h1234);
    cmd_bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("mid_active_set", 32'(set), 2);
    res = 1'b0;
    #1;
    check("mid_rst_set", 32'(set), 0);
    check("mid_rst_m", 32'(M), 0);
    check("mid_rst_d", 32'(D), 0);
    check("mid_rst_level", 32'(level), 0);
    check("mid_rst_ready", 32'(cmd_bus.cmd_ready), 0);
    check("mid_rst_busy", 32'(busy), 0);
    sb.delete();
    @(negedge clk);
    check("mid_rst_ready_low", 32'(cmd_bus.cmd_ready), 0);
    res = 1'b1;
    @(negedge clk);
    check("mid_rst_ready_up", 32'(cmd_bus.cmd_ready), 1);
    check("mid_rst_set_idle", 32'(set), 0);

    // Random mixed stream
    for (int i = 0; i < 12; i++) begin
      rop = SW'($urandom_range(0, 7));
      send(rop, MW'($urandom), DW'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        cmd_bus.cmd_valid = 1'b0;
        @(negedge clk);
      end
    end
    cmd_bus.cmd_valid = 1'b0;
    wait_idle();
    check("final_sb_empty", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
